// File: rtl/ejector_buffered_pkg.sv
// ---------------------------------------------------------------------------
// ejector_buffered_pkg
// Shared definitions for the buffered local ejector:
//   - default channel count and flit width for the router datapath
//   - arbitration mode constants (fixed priority / round-robin)
//   - clog2 helper usable in parameter and port-width expressions
// ---------------------------------------------------------------------------
package ejector_buffered_pkg;

  localparam int WIDTH_PORT_DEF  = 64;
  localparam int NUM_CHANNEL_DEF = 5;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ejector_buffered_arbiter.sv
// ---------------------------------------------------------------------------
// eject_arbiter
// Combinational multi-grant arbiter for the local ejection port.
// Grants up to i_limit of the requesting channels in scan order:
//   ARB_FIXED : scan NUM_CHANNEL-1 down to 0
//   ARB_RR    : scan upward from i_rr_ptr, wrapping
// Ports:
//   i_local_vector  request bit per channel
//   i_limit         max grants this cycle (<= EJECT_WIDTH)
//   i_rr_ptr        round-robin start index
//   o_grant         grant bit per channel (subset of requests)
//   o_grant_idx     granted channel indices in scan order
//   o_grant_cnt     number of grants
//   o_rr_next       last granted index + 1 (mod NUM_CHANNEL), or i_rr_ptr
// ---------------------------------------------------------------------------
module eject_arbiter
  import ejector_buffered_pkg::*;
#(
  parameter int NUM_CHANNEL = NUM_CHANNEL_DEF,
  parameter int EJECT_WIDTH = 2,
  parameter int ARB_MODE    = ARB_FIXED,
  parameter int IDX_W       = 3,
  parameter int CNT_W       = 3
) (
  input  logic [NUM_CHANNEL-1:0] i_local_vector,
  input  logic [CNT_W-1:0]       i_limit,
  input  logic [IDX_W-1:0]       i_rr_ptr,
  output logic [NUM_CHANNEL-1:0] o_grant,
  output logic [IDX_W-1:0]       o_grant_idx [EJECT_WIDTH],
  output logic [CNT_W-1:0]       o_grant_cnt,
  output logic [IDX_W-1:0]       o_rr_next
);

  always_comb begin : scan
    int                     cnt;
    int                     idx_i;
    logic [IDX_W-1:0]       idx;
    logic [NUM_CHANNEL-1:0] mask;

    o_grant   = '0;
    o_rr_next = i_rr_ptr;
    for (int j = 0; j < EJECT_WIDTH; j++) begin
      o_grant_idx[j] = '0;
    end
    cnt   = 0;
    idx_i = 0;
    idx   = '0;
    mask  = '0;

    for (int k = 0; k < NUM_CHANNEL; k++) begin
      if (ARB_MODE == ARB_RR) begin
        idx_i = (int'(i_rr_ptr) + k) % NUM_CHANNEL;
      end else begin
        idx_i = NUM_CHANNEL - 1 - k;
      end
      idx  = IDX_W'(idx_i);
      // One-hot mask keeps the request test free of variable bit-selects.
      mask = NUM_CHANNEL'(1) << idx;
      if (|(i_local_vector & mask) && (cnt < int'(i_limit)) && (cnt < EJECT_WIDTH)) begin
        o_grant = o_grant | mask;
        for (int j = 0; j < EJECT_WIDTH; j++) begin
          if (j == cnt) begin
            o_grant_idx[j] = idx;
          end
        end
        cnt       = cnt + 1;
        o_rr_next = IDX_W'((idx_i + 1) % NUM_CHANNEL);
      end
    end

    o_grant_cnt = CNT_W'(cnt);
  end

endmodule

// File: rtl/ejector_buffered.sv
// ---------------------------------------------------------------------------
// ejector_buffered
// Local ejector accepting up to EJECT_WIDTH locally-destined flits per cycle
// into a DEPTH-entry FIFO that drains to the PE over valid/ready.
// Ports:
//   clk          clock, rising edge
//   reset_n      asynchronous active-low reset
//   flits_in     packed channel flits, channel i at [i*WIDTH_PORT +: WIDTH_PORT]
//   localVector  bit i = flit i wants the local port
//   eject_grant  bit i = flit i accepted this cycle (combinational)
//   localFlit    FIFO head (0 when empty)
//   local_valid  FIFO non-empty
//   local_ready  PE takes localFlit this cycle
//   fifo_count   current occupancy
// ---------------------------------------------------------------------------
module ejector_buffered
  import ejector_buffered_pkg::*;
#(
  parameter int NUM_CHANNEL = NUM_CHANNEL_DEF,
  parameter int WIDTH_PORT  = WIDTH_PORT_DEF,
  parameter int EJECT_WIDTH = 2,
  parameter int DEPTH       = 4,
  parameter int ARB_MODE    = ARB_FIXED
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_CHANNEL*WIDTH_PORT-1:0] flits_in,
  input  logic [NUM_CHANNEL-1:0]            localVector,
  output logic [NUM_CHANNEL-1:0]            eject_grant,
  output logic [WIDTH_PORT-1:0]             localFlit,
  output logic                              local_valid,
  input  logic                              local_ready,
  output logic [clog2(DEPTH):0]             fifo_count
);

  localparam int IDX_W = (clog2(NUM_CHANNEL) < 1) ? 1 : clog2(NUM_CHANNEL);
  localparam int PTR_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH) + 1;
  localparam int MEM_N = 1 << PTR_W;

  logic [WIDTH_PORT-1:0] r_mem [MEM_N];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [IDX_W-1:0]      r_rr_ptr;

  logic [WIDTH_PORT-1:0] w_flit      [NUM_CHANNEL];
  logic [IDX_W-1:0]      w_grant_idx [EJECT_WIDTH];
  logic [PTR_W-1:0]      w_wr_addr   [EJECT_WIDTH];
  logic [CNT_W-1:0]      w_free;
  logic [CNT_W-1:0]      w_limit;
  logic [CNT_W-1:0]      w_grant_cnt;
  logic [IDX_W-1:0]      w_rr_next;
  logic [NUM_CHANNEL-1:0] w_grant;
  logic                  w_pop;

  for (genvar i = 0; i < NUM_CHANNEL; i++) begin : g_unpack
    assign w_flit[i] = flits_in[i*WIDTH_PORT +: WIDTH_PORT];
  end

  // Free space ignores a same-cycle pop so local_ready never reaches the
  // grant path. Limit is forced to 0 while in reset so no grant is issued.
  assign w_free  = CNT_W'(DEPTH) - r_count;
  always_comb begin
    w_limit = '0;
    if (reset_n) begin
      w_limit = (w_free > CNT_W'(EJECT_WIDTH)) ? CNT_W'(EJECT_WIDTH) : w_free;
    end
  end

  eject_arbiter #(
    .NUM_CHANNEL (NUM_CHANNEL),
    .EJECT_WIDTH (EJECT_WIDTH),
    .ARB_MODE    (ARB_MODE),
    .IDX_W       (IDX_W),
    .CNT_W       (CNT_W)
  ) u_arb (
    .i_local_vector (localVector),
    .i_limit        (w_limit),
    .i_rr_ptr       (r_rr_ptr),
    .o_grant        (w_grant),
    .o_grant_idx    (w_grant_idx),
    .o_grant_cnt    (w_grant_cnt),
    .o_rr_next      (w_rr_next)
  );

  assign eject_grant = w_grant;
  assign local_valid = (r_count != '0);
  assign localFlit   = local_valid ? r_mem[r_rd_ptr] : '0;
  assign fifo_count  = r_count;
  assign w_pop       = local_valid & local_ready;

  // Granted flits land in consecutive slots from the write pointer; the
  // pointer width makes the wrap modulo the power-of-two depth.
  for (genvar j = 0; j < EJECT_WIDTH; j++) begin : g_addr
    assign w_wr_addr[j] = r_wr_ptr + PTR_W'(j);
  end

  // Storage is data only: no reset, emptiness is tracked by r_count.
  always_ff @(posedge clk) begin
    for (int j = 0; j < EJECT_WIDTH; j++) begin
      if (j < int'(w_grant_cnt)) begin
        r_mem[w_wr_addr[j]] <= w_flit[w_grant_idx[j]];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_grant_cnt);
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
      r_count  <= r_count + w_grant_cnt - CNT_W'(w_pop);
      if (ARB_MODE == ARB_RR) begin
        r_rr_ptr <= w_rr_next;
      end
    end
  end

endmodule

// File: tb/tb_ejector_buffered.sv
module tb_ejector_buffered;

  localparam int N  = 5;
  localparam int W  = 64;
  localparam int D  = 4;
  localparam int EW = 2;

  logic           clk;
  logic           reset_n;
  logic [N*W-1:0] flits_in;
  logic [N-1:0]   localVector;
  logic           local_ready;

  logic [N-1:0]   g0, g1;
  logic [W-1:0]   lf0, lf1;
  logic           lv0, lv1;
  logic [2:0]     cnt0, cnt1;

  int checks;
  int failures;

  ejector_buffered #(.NUM_CHANNEL(N), .WIDTH_PORT(W), .EJECT_WIDTH(EW), .DEPTH(D), .ARB_MODE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .flits_in(flits_in), .localVector(localVector),
    .eject_grant(g0), .localFlit(lf0), .local_valid(lv0), .local_ready(local_ready),
    .fifo_count(cnt0)
  );

  ejector_buffered #(.NUM_CHANNEL(N), .WIDTH_PORT(W), .EJECT_WIDTH(EW), .DEPTH(D), .ARB_MODE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .flits_in(flits_in), .localVector(localVector),
    .eject_grant(g1), .localFlit(lf1), .local_valid(lv1), .local_ready(local_ready),
    .fifo_count(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] fv(input int base, input int ch);
    return 64'hF000_0000_0000_0000 | (64'(base) << 8) | 64'(ch);
  endfunction

  task automatic set_flits(input int base);
    for (int i = 0; i < N; i++) flits_in[i*W +: W] = fv(base, i);
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    localVector = '0;
    local_ready = 1'b0;
    set_flits(0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Reference grant: fixed priority scans high-to-low, round-robin scans up from rr.
  function automatic void model_grant(input logic [N-1:0] vec, input int lim, input bit rr_mode,
                                      input int rr, output logic [N-1:0] g, output int ord[N],
                                      output int n, output int rr_n);
    int idx;
    g = '0; n = 0; rr_n = rr;
    for (int k = 0; k < N; k++) ord[k] = 0;
    for (int k = 0; k < N; k++) begin
      idx = rr_mode ? (rr + k) % N : N - 1 - k;
      if (vec[idx] && n < lim) begin
        g[idx] = 1'b1; ord[n] = idx; n++; rr_n = (idx + 1) % N;
      end
    end
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    localVector = 5'b11111;
    local_ready = 1'b1;
    #1;
    checks++; if (g0 !== 5'b0) begin failures++; $display("FAIL reset_grant0 got=%b exp=00000", g0); end
    checks++; if (g1 !== 5'b0) begin failures++; $display("FAIL reset_grant1 got=%b exp=00000", g1); end
    checks++; if (lv0 !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", lv0); end
    checks++; if (lf0 !== '0) begin failures++; $display("FAIL reset_flit got=%h exp=0", lf0); end
    checks++; if (cnt0 !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", cnt0); end
    do_reset();
  endtask

  task automatic test_fixed_priority();
    set_flits(1);
    localVector = 5'b10110;
    local_ready = 1'b0;
    #1;
    checks++; if (g0 !== 5'b10100) begin failures++; $display("FAIL fixed_grant got=%b exp=10100", g0); end
    @(posedge clk); #1;
    localVector = '0;
    checks++; if (cnt0 !== 3'd2) begin failures++; $display("FAIL fixed_count got=%0d exp=2", cnt0); end
    checks++; if (lf0 !== fv(1, 4)) begin failures++; $display("FAIL fixed_head got=%h exp=%h", lf0, fv(1, 4)); end
    checks++; if (lv0 !== 1'b1) begin failures++; $display("FAIL fixed_valid got=%b exp=1", lv0); end
    local_ready = 1'b1;
    @(posedge clk); #1;
    local_ready = 1'b0;
    checks++; if (lf0 !== fv(1, 2)) begin failures++; $display("FAIL fixed_pop_head got=%h exp=%h", lf0, fv(1, 2)); end
    checks++; if (cnt0 !== 3'd1) begin failures++; $display("FAIL fixed_pop_count got=%0d exp=1", cnt0); end
  endtask

  task automatic test_fill_to_full();
    set_flits(2);
    localVector = 5'b10100;
    #1;
    checks++; if (g0 !== 5'b10100) begin failures++; $display("FAIL fill_grant got=%b exp=10100", g0); end
    @(posedge clk); #1;
    checks++; if (cnt0 !== 3'd3) begin failures++; $display("FAIL fill_count3 got=%0d exp=3", cnt0); end
    set_flits(3);
    localVector = 5'b00011;
    #1;
    checks++; if (g0 !== 5'b00010) begin failures++; $display("FAIL limit1_grant got=%b exp=00010", g0); end
    @(posedge clk); #1;
    checks++; if (cnt0 !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", cnt0); end
    localVector = 5'b11111;
    #1;
    checks++; if (g0 !== 5'b0) begin failures++; $display("FAIL full_grant got=%b exp=00000", g0); end
    @(posedge clk); #1;
    checks++; if (cnt0 !== 3'd4) begin failures++; $display("FAIL hold_count got=%0d exp=4", cnt0); end
    checks++; if (lf0 !== fv(1, 2)) begin failures++; $display("FAIL hold_head got=%h exp=%h", lf0, fv(1, 2)); end
    checks++; if (lv0 !== 1'b1) begin failures++; $display("FAIL hold_valid got=%b exp=1", lv0); end
  endtask

  task automatic test_full_with_pop();
    logic [W-1:0] exp_q [3];
    localVector = 5'b00001;
    local_ready = 1'b1;
    #1;
    checks++; if (g0 !== 5'b0) begin failures++; $display("FAIL full_ready_grant got=%b exp=00000", g0); end
    @(posedge clk); #1;
    checks++; if (cnt0 !== 3'd3) begin failures++; $display("FAIL full_pop_count got=%0d exp=3", cnt0); end
    checks++; if (lf0 !== fv(2, 4)) begin failures++; $display("FAIL full_pop_head got=%h exp=%h", lf0, fv(2, 4)); end
    checks++; if (g0 !== 5'b00001) begin failures++; $display("FAIL pushpop_grant got=%b exp=00001", g0); end
    @(posedge clk); #1;
    checks++; if (cnt0 !== 3'd3) begin failures++; $display("FAIL pushpop_count got=%0d exp=3", cnt0); end
    localVector = '0;
    exp_q[0] = fv(2, 2); exp_q[1] = fv(3, 1); exp_q[2] = fv(3, 0);
    for (int k = 0; k < 3; k++) begin
      checks++; if (lf0 !== exp_q[k]) begin failures++; $display("FAIL drain_order[%0d] got=%h exp=%h", k, lf0, exp_q[k]); end
      @(posedge clk); #1;
    end
    checks++; if (lv0 !== 1'b0) begin failures++; $display("FAIL drained_valid got=%b exp=0", lv0); end
    checks++; if (lf0 !== '0) begin failures++; $display("FAIL drained_flit got=%h exp=0", lf0); end
    @(posedge clk); #1;
    checks++; if (cnt0 !== 3'd0) begin failures++; $display("FAIL empty_ready_count got=%0d exp=0", cnt0); end
    local_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    do_reset();
    set_flits(5);
    localVector = 5'b11111;
    local_ready = 1'b1;
    #1;
    checks++; if (dut1.r_rr_ptr !== 3'd0) begin failures++; $display("FAIL rr_start got=%0d exp=0", dut1.r_rr_ptr); end
    checks++; if (g1 !== 5'b00011) begin failures++; $display("FAIL rr_grant1 got=%b exp=00011", g1); end
    @(posedge clk); #1;
    checks++; if (dut1.r_rr_ptr !== 3'd2) begin failures++; $display("FAIL rr_ptr1 got=%0d exp=2", dut1.r_rr_ptr); end
    checks++; if (g1 !== 5'b01100) begin failures++; $display("FAIL rr_grant2 got=%b exp=01100", g1); end
    @(posedge clk); #1;
    checks++; if (dut1.r_rr_ptr !== 3'd4) begin failures++; $display("FAIL rr_ptr2 got=%0d exp=4", dut1.r_rr_ptr); end
    checks++; if (g1 !== 5'b10000) begin failures++; $display("FAIL rr_grant3 got=%b exp=10000", g1); end
    @(posedge clk); #1;
    checks++; if (dut1.r_rr_ptr !== 3'd0) begin failures++; $display("FAIL rr_ptr3 got=%0d exp=0", dut1.r_rr_ptr); end
    checks++; if (cnt1 !== 3'd3) begin failures++; $display("FAIL rr_count got=%0d exp=3", cnt1); end
    checks++; if (lf1 !== fv(5, 2)) begin failures++; $display("FAIL rr_head got=%h exp=%h", lf1, fv(5, 2)); end
    localVector = '0;
    local_ready = 1'b0;
  endtask

  task automatic test_reset_mid_operation();
    do_reset();
    set_flits(6);
    localVector = 5'b00111;
    @(posedge clk); #1;
    localVector = 5'b00001;
    @(posedge clk); #1;
    localVector = '0;
    checks++; if (cnt0 !== 3'd3) begin failures++; $display("FAIL mid_pre_count got=%0d exp=3", cnt0); end
    checks++; if (lv0 !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got=%b exp=1", lv0); end
    #3 reset_n = 1'b0;
    #1;
    checks++; if (lv0 !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", lv0); end
    checks++; if (lf0 !== '0) begin failures++; $display("FAIL mid_flit got=%h exp=0", lf0); end
    checks++; if (cnt0 !== 3'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", cnt0); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    set_flits(7);
    localVector = 5'b01000;
    #1;
    checks++; if (g0 !== 5'b01000) begin failures++; $display("FAIL post_grant got=%b exp=01000", g0); end
    @(posedge clk); #1;
    localVector = '0;
    checks++; if (dut0.r_mem[0] !== fv(7, 3)) begin failures++; $display("FAIL post_slot0 got=%h exp=%h", dut0.r_mem[0], fv(7, 3)); end
    checks++; if (lf0 !== fv(7, 3)) begin failures++; $display("FAIL post_head got=%h exp=%h", lf0, fv(7, 3)); end
    checks++; if (cnt0 !== 3'd1) begin failures++; $display("FAIL post_count got=%0d exp=1", cnt0); end
  endtask

  task automatic test_random();
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    int mc0, mc1, rr1, rr_dummy, rr_n, n0, n1, base;
    int ord0[N];
    int ord1[N];
    logic [N-1:0] e0, e1;
    do_reset();
    mc0 = 0; mc1 = 0; rr1 = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      base = 100 + cyc;
      set_flits(base);
      localVector = N'($urandom_range(0, 31));
      local_ready = ($urandom_range(0, 99) < 45);
      #1;
      model_grant(localVector, (EW < D - mc0) ? EW : D - mc0, 1'b0, 0, e0, ord0, n0, rr_dummy);
      model_grant(localVector, (EW < D - mc1) ? EW : D - mc1, 1'b1, rr1, e1, ord1, n1, rr_n);
      checks++; if (g0 !== e0) begin failures++; $display("FAIL rnd_grant0 cyc=%0d got=%b exp=%b", cyc, g0, e0); end
      checks++; if (g1 !== e1) begin failures++; $display("FAIL rnd_grant1 cyc=%0d got=%b exp=%b", cyc, g1, e1); end
      checks++; if ((g0 & ~localVector) !== '0) begin failures++; $display("FAIL rnd_subset0 cyc=%0d got=%b req=%b", cyc, g0, localVector); end
      checks++; if ((g1 & ~localVector) !== '0) begin failures++; $display("FAIL rnd_subset1 cyc=%0d got=%b req=%b", cyc, g1, localVector); end
      checks++; if (cnt0 > 3'(D) || cnt1 > 3'(D)) begin failures++; $display("FAIL rnd_overflow cyc=%0d got=%0d/%0d max=%0d", cyc, cnt0, cnt1, D); end
      checks++; if (cnt0 !== 3'(mc0)) begin failures++; $display("FAIL rnd_count0 cyc=%0d got=%0d exp=%0d", cyc, cnt0, mc0); end
      checks++; if (cnt1 !== 3'(mc1)) begin failures++; $display("FAIL rnd_count1 cyc=%0d got=%0d exp=%0d", cyc, cnt1, mc1); end
      checks++; if (lv0 !== (mc0 != 0) || (mc0 != 0 && lf0 !== q0[0])) begin
        failures++; $display("FAIL rnd_head0 cyc=%0d got=%b/%h exp=%b/%h", cyc, lv0, lf0, mc0 != 0, (mc0 != 0) ? q0[0] : '0);
      end
      checks++; if (lv1 !== (mc1 != 0) || (mc1 != 0 && lf1 !== q1[0])) begin
        failures++; $display("FAIL rnd_head1 cyc=%0d got=%b/%h exp=%b/%h", cyc, lv1, lf1, mc1 != 0, (mc1 != 0) ? q1[0] : '0);
      end
      if (local_ready && mc0 != 0) begin void'(q0.pop_front()); mc0--; end
      if (local_ready && mc1 != 0) begin void'(q1.pop_front()); mc1--; end
      for (int j = 0; j < n0; j++) q0.push_back(fv(base, ord0[j]));
      for (int j = 0; j < n1; j++) q1.push_back(fv(base, ord1[j]));
      mc0 += n0;
      mc1 += n1;
      rr1 = rr_n;
      @(posedge clk); #1;
    end
    localVector = '0;
    local_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    localVector = '0;
    local_ready = 1'b0;
    set_flits(0);
    #12;
    test_reset();
    test_fixed_priority();
    test_fill_to_full();
    test_full_with_pop();
    test_round_robin();
    test_reset_mid_operation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ejector_buffered.md
Name: ejector_buffered

Overview:
Parametrised successor to the single-flit local ejector in the router datapath.
- Each cycle it accepts up to EJECT_WIDTH locally-destined flits from the NUM_CHANNEL channel flits, instead of exactly one.
- Accepted flits go into an ejection FIFO, which drains to the local PE over a valid/ready handshake.
- A grant vector goes back to the permutation/deflection stage; any local request not granted stays in the network and is deflected.

Parameters:
NUM_CHANNEL, 5, number of input channels (flit0..flitN-1).
WIDTH_PORT, 64, flit width in bits.
EJECT_WIDTH, 2, max flits accepted per cycle (1..NUM_CHANNEL).
DEPTH, 4, ejection FIFO entries (power of 2, DEPTH >= EJECT_WIDTH).
ARB_MODE, 0, 0 = fixed priority (highest index wins), 1 = round-robin.

Ports:
clk  input  1  clock, rising edge.
reset_n  input  1  asynchronous reset, active low.
flits_in  input  NUM_CHANNEL*WIDTH_PORT  packed flits; channel i at bits [i*WIDTH_PORT +: WIDTH_PORT].
localVector  input  NUM_CHANNEL  bit i = flit i is destined for the local port.
eject_grant  output  NUM_CHANNEL  bit i = flit i accepted this cycle (combinational).
localFlit  output  WIDTH_PORT  FIFO head flit.
local_valid  output  1  FIFO non-empty.
local_ready  input  1  PE accepts localFlit this cycle.
fifo_count  output  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (asynchronous, reset_n = 0):
  - count = 0, write and read pointers = 0, rr_ptr = 0.
  - eject_grant = 0, local_valid = 0, localFlit = 0.
- Free slots: free = DEPTH - count.
  - A pop in the same cycle is not credited; this keeps local_ready off the grant path.
  - Grant limit: limit = min(EJECT_WIDTH, free).
- Arbitration, ARB_MODE = 0:
  - Scan indices NUM_CHANNEL-1 down to 0.
  - Grant the first `limit` set bits of localVector.
- Arbitration, ARB_MODE = 1:
  - Scan upward from rr_ptr, wrapping modulo NUM_CHANNEL.
  - Grant the first `limit` set bits.
  - If at least one grant: rr_ptr <= (last granted index + 1) mod NUM_CHANNEL on the clock edge. Otherwise rr_ptr holds.
- Grant rules:
  - eject_grant is a subset of localVector.
  - popcount(eject_grant) <= limit.
  - localVector = 0 gives eject_grant = 0.
- Push: granted flits are written on the same clock edge, in scan order, to consecutive slots from the write pointer.
- Pop: when local_valid && local_ready, the read pointer advances by 1 on the clock edge.
- Pointers wrap modulo DEPTH.
- Occupancy: count_next = count + pushes - pop. Push and pop in the same cycle are both honoured.
- Latency: a flit granted in cycle t is at localFlit no earlier than cycle t+1.
- FIFO output:
  - localFlit = mem[rd_ptr] when count != 0, otherwise 0.
  - local_valid = (count != 0).
- Ordering: FIFO order, strict.
- Boundaries:
  - Full (count = DEPTH): eject_grant = 0 whatever local_ready is.
  - Overflow and underflow are impossible by construction. The bench asserts count <= DEPTH, and that no pop occurs when empty.
  - local_ready while empty: ignored, no state change.
  - Holding: localFlit and local_valid stay stable while local_valid && !local_ready.
- Reset mid-operation: FIFO contents are discarded and every output returns to its reset value immediately.

Decomposition:
- Shared package/header (extend global.vh), holding:
  - WIDTH_PORT and NUM_CHANNEL defaults.
  - ARB_FIXED = 0 and ARB_RR = 1 constants.
  - A clog2 function.
- Sub-module eject_arbiter, combinational:
  - Inputs: localVector, limit, rr_ptr.
  - Outputs: eject_grant, an ordered list of granted indices, grant count, and the next rr_ptr.
  - The top level holds the FIFO storage, pointers and counter.

Test Plan:
1. Defaults, ARB_MODE = 0, empty FIFO, localVector = 5'b10110, local_ready = 0 → eject_grant = 5'b10100. Next cycle: count = 2, localFlit = flit4. After one pop: localFlit = flit2.
2. count = 3 (DEPTH = 4), localVector = 5'b00011 → eject_grant = 5'b00010, count becomes 4. Next cycle with localVector = 5'b11111 → eject_grant = 0.
3. ARB_MODE = 1, rr_ptr = 0, localVector = 5'b11111 held for 3 cycles with local_ready = 1:
   - Grants are 00011, then 01100, then 10000 (grant limited to 1 by free slots).
   - Check rr_ptr is 2, 4, 0 after each grant.
4. Full FIFO with local_ready = 1 and localVector = 5'b00001 → no grant that cycle. Count goes 4→3. Next cycle the grant is 5'b00001 and count stays 3 (push + pop).
5. Reset mid-operation: count = 3 and local_valid = 1, then reset_n falls asynchronously between edges → local_valid = 0, localFlit = 0, fifo_count = 0 at once. After release, the first grant writes slot 0.
6. Random localVector and local_ready over 10k cycles against a scoreboard queue:
   - Ejected sequence matches granted order.
   - eject_grant is always a subset of localVector.
   - count never exceeds DEPTH.
